unidad_cortocircuito: RTL and testbench
=======================================

UNIDAD_CORTOCIRCUITO -- requirements
Module: unidad_cortocircuito

Interface
REQ-001 SHALL have parameter NBITS_REG, default 5, register-address width.
REQ-002 SHALL have parameter CORTOCIRCUITO, default 3, forwarding-select width.
REQ-003 SHALL have port i_clk  input  1  single clock, rising edge.
REQ-004 SHALL have port i_reset  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port i_enable  input  1  global pipeline advance (debug step); 0 = hold all state.
REQ-006 SHALL have ports i_ID_rs, i_ID_rt  input  NBITS_REG  source registers of instruction in ID.
REQ-007 SHALL have ports i_ID_usa_rs, i_ID_usa_rt  input  1  ID instruction actually reads rs / rt.
REQ-008 SHALL have port i_ID_dest  input  NBITS_REG  destination register of ID instruction.
REQ-009 SHALL have ports i_ID_RegWrite, i_ID_MemRead  input  1  ID instruction writes register / is a load.
REQ-010 SHALL have ports o_EX_UnidadCortocircuito_A, o_EX_UnidadCortocircuito_B  output  CORTOCIRCUITO  operand selects for EX-stage rs / rt.
REQ-011 SHALL have port o_stall  output  1  freeze PC and IF/ID, insert bubble.
REQ-012 SHALL have port o_stall_count  output  16  stall-cycle count (see Configuration).

Function
REQ-013 SHALL hold three internal slots EX, MEM, WB, each {rs, rt, usa_rs, usa_rt, dest, RegWrite, MemRead}.
REQ-014 On rising i_clk with i_enable=1, o_stall=0: ID->EX, EX->MEM, MEM->WB.
REQ-015 On rising i_clk with i_enable=1, o_stall=1: bubble (all flags 0, fields 0) ->EX, EX->MEM, MEM->WB.
REQ-016 With i_enable=0 all slots SHALL hold; o_stall SHALL still be evaluated combinationally.
REQ-017 Select codes: 3'b001 = EX/MEM value, 3'b010 = MEM/WB value, 3'b000 = register-file value; other codes never driven.
REQ-018 Select A SHALL be 001 if EX.usa_rs, MEM.RegWrite, MEM.dest!=0, MEM.dest==EX.rs; else 010 if same test against WB; else 000.
REQ-019 Select B SHALL follow REQ-018 using EX.usa_rt and EX.rt.
REQ-020 MEM match SHALL take priority over WB match when both hit (newest value wins).
REQ-021 Selects SHALL depend only on registered slot state (zero-cycle latency within EX cycle, no input path).
REQ-022 o_stall SHALL be 1 iff EX.MemRead, EX.RegWrite, EX.dest!=0, and (i_ID_usa_rs and i_ID_rs==EX.dest, or i_ID_usa_rt and i_ID_rt==EX.dest).
REQ-023 Load-use stall SHALL last exactly one enabled cycle: bubble in EX clears the condition; after it the load sits in MEM and REQ-018 yields 001.
REQ-024 Register 0 SHALL never cause forwarding or stall.
REQ-025 Equality compares SHALL use full NBITS_REG width.

Reset
REQ-026 i_reset=1 SHALL immediately clear all slots to bubble, regardless of i_clk or i_enable.
REQ-027 During and after reset: both selects 3'b000, o_stall=0 (unless ID alone satisfies REQ-022, impossible with empty EX), o_stall_count=0.
REQ-028 Reset mid-stall SHALL abort the stall; no bubble credit carried over.

Configuration
REQ-029 Macro STALL_COUNT_EN defined: o_stall_count SHALL increment by 1 on each rising i_clk with i_enable=1 and o_stall=1, saturating at 16'hFFFF.
REQ-030 Macro STALL_COUNT_EN undefined: o_stall_count SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-031 add $3<-..., then add $4,$3,$5 -> next cycle select A=001, B=000, o_stall=0.
REQ-032 add $3, nop, sub $6,$7,$3 -> in sub EX cycle select B=010, A=000.
REQ-033 add $3 then add $3 then or $8,$3,$3 -> both selects 001 (MEM priority over WB).
REQ-034 lw $2, then add $9,$2,$1 -> o_stall=1 one cycle, bubble in EX, next cycle select A=001, o_stall=0; with STALL_COUNT_EN o_stall_count=1.
REQ-035 add $0,... then use $0 -> selects 000, no stall; lw $2 pending with i_enable=0 for 4 cycles -> o_stall stays 1, counter unchanged.
REQ-036 Assert i_reset between clock edges during stall -> o_stall=0, selects 000, count 0 immediately.

Source files
------------

// File: rtl/unidad_cortocircuito.sv
// Forwarding/hazard unit: EX/MEM/WB shadow slots drive zero-latency operand selects; load-use raises o_stall for one enabled cycle.
// `define STALL_COUNT_EN to add a saturating stall counter on o_stall_count (constant 0 otherwise).
module unidad_cortocircuito #(
  parameter int NBITS_REG     = 5,
  parameter int CORTOCIRCUITO = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic [NBITS_REG-1:0]     i_ID_rs,
  input  logic [NBITS_REG-1:0]     i_ID_rt,
  input  logic                     i_ID_usa_rs,
  input  logic                     i_ID_usa_rt,
  input  logic [NBITS_REG-1:0]     i_ID_dest,
  input  logic                     i_ID_RegWrite,
  input  logic                     i_ID_MemRead,
  output logic [CORTOCIRCUITO-1:0] o_EX_UnidadCortocircuito_A,
  output logic [CORTOCIRCUITO-1:0] o_EX_UnidadCortocircuito_B,
  output logic                     o_stall,
  output logic [15:0]              o_stall_count
);

  typedef struct packed {
    logic [NBITS_REG-1:0] rs;
    logic [NBITS_REG-1:0] rt;
    logic                 usa_rs;
    logic                 usa_rt;
    logic [NBITS_REG-1:0] dest;
    logic                 reg_write;
    logic                 mem_read;
  } slot_t;

  localparam logic [CORTOCIRCUITO-1:0] SEL_RF    = '0;
  localparam logic [CORTOCIRCUITO-1:0] SEL_EXMEM = CORTOCIRCUITO'(1);
  localparam logic [CORTOCIRCUITO-1:0] SEL_MEMWB = CORTOCIRCUITO'(2);

  slot_t id_slot;
  slot_t ex_q;
  slot_t mem_q;
  slot_t wb_q;

  always_comb begin
    id_slot           = '0;
    id_slot.rs        = i_ID_rs;
    id_slot.rt        = i_ID_rt;
    id_slot.usa_rs    = i_ID_usa_rs;
    id_slot.usa_rt    = i_ID_usa_rt;
    id_slot.dest      = i_ID_dest;
    id_slot.reg_write = i_ID_RegWrite;
    id_slot.mem_read  = i_ID_MemRead;
  end

  // A stalled advance loads a bubble into EX while older slots keep draining.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (i_enable) begin
      ex_q  <= o_stall ? '0 : id_slot;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  function automatic logic writes_reg(input slot_t s, input logic [NBITS_REG-1:0] src);
    return s.reg_write && (s.dest != '0) && (s.dest == src);
  endfunction

  // MEM is checked first so the newest producer wins.
  function automatic logic [CORTOCIRCUITO-1:0] fwd_sel(input logic usa,
                                                       input logic [NBITS_REG-1:0] src,
                                                       input slot_t m,
                                                       input slot_t w);
    if (usa && writes_reg(m, src)) return SEL_EXMEM;
    if (usa && writes_reg(w, src)) return SEL_MEMWB;
    return SEL_RF;
  endfunction

  assign o_EX_UnidadCortocircuito_A = fwd_sel(ex_q.usa_rs, ex_q.rs, mem_q, wb_q);
  assign o_EX_UnidadCortocircuito_B = fwd_sel(ex_q.usa_rt, ex_q.rt, mem_q, wb_q);

  assign o_stall = ex_q.mem_read && ex_q.reg_write && (ex_q.dest != '0) &&
                   ((i_ID_usa_rs && (i_ID_rs == ex_q.dest)) ||
                    (i_ID_usa_rt && (i_ID_rt == ex_q.dest)));

  // Fields carried for slot completeness but not consumed by any decision.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{mem_q.rs, mem_q.rt, mem_q.usa_rs, mem_q.usa_rt, mem_q.mem_read,
                              wb_q.rs, wb_q.rt, wb_q.usa_rs, wb_q.usa_rt, wb_q.mem_read};

`ifdef STALL_COUNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
    end else if (i_enable && o_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign o_stall_count = stall_cnt_q;
`else
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_unidad_cortocircuito.sv
// Scoreboard bench: driver feeds instructions and pushes expected selects/stall/count; negedge monitor pops and compares.
module tb_unidad_cortocircuito;

  logic       i_clk;
  logic       i_reset;
  logic       i_enable;
  logic [4:0] i_ID_rs, i_ID_rt, i_ID_dest;
  logic       i_ID_usa_rs, i_ID_usa_rt, i_ID_RegWrite, i_ID_MemRead;
  logic [2:0] sel_a, sel_b;
  logic       stall;
  logic [15:0] stall_count;

  unidad_cortocircuito #(.NBITS_REG(5), .CORTOCIRCUITO(3)) dut (
    .i_clk                      (i_clk),
    .i_reset                    (i_reset),
    .i_enable                   (i_enable),
    .i_ID_rs                    (i_ID_rs),
    .i_ID_rt                    (i_ID_rt),
    .i_ID_usa_rs                (i_ID_usa_rs),
    .i_ID_usa_rt                (i_ID_usa_rt),
    .i_ID_dest                  (i_ID_dest),
    .i_ID_RegWrite              (i_ID_RegWrite),
    .i_ID_MemRead               (i_ID_MemRead),
    .o_EX_UnidadCortocircuito_A (sel_a),
    .o_EX_UnidadCortocircuito_B (sel_b),
    .o_stall                    (stall),
    .o_stall_count              (stall_count)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    bit [4:0] rs;
    bit [4:0] rt;
    bit       urs;
    bit       urt;
    bit [4:0] dest;
    bit       rw;
    bit       mr;
  } ins_t;

  typedef struct {
    logic [2:0]  a;
    logic [2:0]  b;
    logic        st;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference: instructions in flight, index 0 = EX, 1 = MEM, 2 = WB.
  ins_t inflight[$];
  ins_t id_prev;
  bit   en_prev;
  bit   stall_prev;
  int   cnt_model;

  function automatic ins_t mk(int rs, int rt, bit urs, bit urt, int dest, bit rw, bit mr);
    ins_t r;
    r.rs = 5'(rs); r.rt = 5'(rt); r.urs = urs; r.urt = urt;
    r.dest = 5'(dest); r.rw = rw; r.mr = mr;
    return r;
  endfunction

  function automatic ins_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void clear_model();
    inflight.delete();
    for (int k = 0; k < 3; k++) inflight.push_back(nop());
    cnt_model = 0;
  endfunction

  // Value source for a register read by the EX instruction: newest older producer wins.
  function automatic logic [2:0] expect_sel(bit uses, bit [4:0] src);
    if (!uses || src == 0) return 3'd0;
    for (int k = 1; k <= 2; k++)
      if (inflight[k].rw && inflight[k].dest == src) return (k == 1) ? 3'd1 : 3'd2;
    return 3'd0;
  endfunction

  function automatic bit expect_stall(ins_t id);
    ins_t ld;
    ld = inflight[0];
    if (!(ld.mr && ld.rw && ld.dest != 0)) return 1'b0;
    return (id.urs && id.rs == ld.dest) || (id.urt && id.rt == ld.dest);
  endfunction

  task automatic cycle(input ins_t id, input bit en, input bit rst_mid, input bit release_rst);
    exp_t e;
    @(posedge i_clk);
    #1;
    if (i_reset) begin
      clear_model();
    end else if (en_prev) begin
      inflight.push_front(stall_prev ? nop() : id_prev);
      void'(inflight.pop_back());
`ifdef STALL_COUNT_EN
      if (stall_prev && cnt_model < 65535) cnt_model++;
`endif
    end
    if (release_rst) i_reset = 1'b0;
    i_ID_rs = id.rs; i_ID_rt = id.rt; i_ID_usa_rs = id.urs; i_ID_usa_rt = id.urt;
    i_ID_dest = id.dest; i_ID_RegWrite = id.rw; i_ID_MemRead = id.mr;
    i_enable = en;
    id_prev = id;
    en_prev = en;
    #1;
    if (rst_mid) begin
      i_reset = 1'b1;
      clear_model();
    end
    e.a   = expect_sel(inflight[0].urs, inflight[0].rs);
    e.b   = expect_sel(inflight[0].urt, inflight[0].rt);
    e.st  = expect_stall(id);
    e.cnt = 16'(cnt_model);
    stall_prev = e.st;
    sb.push_back(e);
  endtask

  task automatic run(input ins_t id);
    cycle(id, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (sel_a !== e.a) begin
          failures++;
          $display("FAIL sel_a t=%0t got=%b exp=%b", $time, sel_a, e.a);
        end
        checks++;
        if (sel_b !== e.b) begin
          failures++;
          $display("FAIL sel_b t=%0t got=%b exp=%b", $time, sel_b, e.b);
        end
        checks++;
        if (stall !== e.st) begin
          failures++;
          $display("FAIL stall t=%0t got=%b exp=%b", $time, stall, e.st);
        end
        checks++;
        if (stall_count !== e.cnt) begin
          failures++;
          $display("FAIL stall_count t=%0t got=%0d exp=%0d", $time, stall_count, e.cnt);
        end
      end
    end
  end

  initial begin : driver
    ins_t r;
    int   budget;
    i_reset = 1'b1; i_enable = 1'b0;
    i_ID_rs = '0; i_ID_rt = '0; i_ID_usa_rs = 1'b0; i_ID_usa_rt = 1'b0;
    i_ID_dest = '0; i_ID_RegWrite = 1'b0; i_ID_MemRead = 1'b0;
    id_prev = nop(); en_prev = 1'b0; stall_prev = 1'b0;
    clear_model();

    // Reset state, with ID presenting a dependent-looking instruction.
    cycle(mk(2, 2, 1, 1, 4, 1, 0), 1'b1, 1'b0, 1'b0);
    cycle(nop(), 1'b1, 1'b0, 1'b1);

    // EX/MEM forward to rs.
    run(mk(1, 2, 1, 1, 3, 1, 0));
    run(mk(3, 5, 1, 1, 4, 1, 0));
    run(nop());
    // MEM/WB forward to rt.
    run(mk(1, 2, 1, 1, 3, 1, 0));
    run(nop());
    run(mk(7, 3, 1, 1, 6, 1, 0));
    run(nop());
    // Two producers of $3: newest wins on both operands.
    run(mk(1, 2, 1, 1, 3, 1, 0));
    run(mk(4, 5, 1, 1, 3, 1, 0));
    run(mk(3, 3, 1, 1, 8, 1, 0));
    run(nop()); run(nop());
    // Load-use: one stall, then EX/MEM forward.
    run(mk(0, 0, 1, 0, 2, 1, 1));
    run(mk(2, 1, 1, 1, 9, 1, 0));
    run(mk(2, 1, 1, 1, 9, 1, 0));
    run(nop()); run(nop());
    // Register 0 never forwards or stalls.
    run(mk(1, 2, 1, 1, 0, 1, 1));
    run(mk(0, 0, 1, 1, 5, 1, 0));
    run(nop()); run(nop());
    // Pending load with enable low: stall holds, counter frozen.
    run(mk(0, 0, 1, 0, 2, 1, 1));
    for (int k = 0; k < 4; k++) cycle(mk(1, 2, 1, 1, 9, 1, 0), 1'b0, 1'b0, 1'b0);
    run(mk(1, 2, 1, 1, 9, 1, 0));
    run(mk(1, 2, 1, 1, 9, 1, 0));
    run(nop());
    // Reset asserted mid-cycle during a stall.
    run(mk(0, 0, 1, 0, 2, 1, 1));
    cycle(mk(2, 0, 1, 0, 9, 1, 0), 1'b1, 1'b1, 1'b0);
    cycle(mk(2, 0, 1, 0, 9, 1, 0), 1'b1, 1'b0, 1'b1);
    run(nop());

    // Random traffic over a small register set for frequent hazards.
    for (int n = 0; n < 600; n++) begin
      r.rs   = 5'($urandom_range(0, 5));
      r.rt   = 5'($urandom_range(0, 5));
      r.urs  = 1'($urandom_range(0, 1));
      r.urt  = 1'($urandom_range(0, 1));
      r.dest = 5'($urandom_range(0, 5));
      r.rw   = ($urandom_range(0, 3) != 0);
      r.mr   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0)
        cycle(r, 1'b1, 1'b1, 1'b0);
      else
        cycle(r, ($urandom_range(0, 4) != 0), 1'b0, i_reset);
    end
    cycle(nop(), 1'b1, 1'b0, 1'b1);

    budget = 0;
    while (sb.size() != 0 && budget < 10) begin
      @(negedge i_clk);
      budget++;
    end
    @(posedge i_clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
